// File: rtl/fxp_to_fp_enc.sv
// Three-stage encoder: signed fixed-point accumulator -> packed minifloat {sign, exp, man}.
// Rounds to nearest-even and saturates to the largest finite value; inf/NaN are never produced.
module fxp_to_fp_enc #(
  parameter int exp_width = 5,
  parameter int man_width = 2,
  parameter int in_width  = 73,
  parameter int frac_bits = 2 * ((2 ** (exp_width - 1) - 1) - 1 + man_width),
  parameter int bit_width = 1 + exp_width + man_width
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [in_width-1:0]  i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [bit_width-1:0] o_fp
);

  localparam int bias    = 2 ** (exp_width - 1) - 1;
  localparam int sh_w    = in_width + man_width + 2;
  localparam int sub_sh  = frac_bits + 1 - bias - man_width;
  localparam int ef_w    = $clog2(in_width + 2 ** exp_width) + 1;
  localparam int exp_max = 2 ** exp_width - 2;

  localparam logic [sh_w-1:0] sh_one = sh_w'(1);

  logic en;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_q, s1_sign_d;
  logic                 s1_zero_q, s1_zero_d;
  logic [in_width-1:0]  s1_mag_q, s1_mag_d;

  logic                 s2_valid_q, s2_valid_d;
  logic                 s2_sign_q, s2_sign_d;
  logic [ef_w-1:0]      s2_exp_q, s2_exp_d;
  logic [man_width-1:0] s2_man_q, s2_man_d;
  logic                 s2_g_q, s2_g_d;
  logic                 s2_r_q, s2_r_d;
  logic                 s2_s_q, s2_s_d;

  logic                 o_valid_q, o_valid_d;
  logic [bit_width-1:0] o_fp_q, o_fp_d;

  int                   lead;
  int                   e_int;
  int                   sh;
  logic                 normal;
  logic [sh_w-1:0]      ext;
  logic [sh_w-1:0]      lost_mask;

  logic                 inc;
  logic [man_width:0]   man_sum;
  logic [ef_w-1:0]      exp_r;

  assign en      = !(o_valid_q && !i_ready);
  assign o_ready = en;
  assign o_valid = o_valid_q;
  assign o_fp    = o_fp_q;

  // Normalise: one shift amount serves both the normal and the subnormal case;
  // the mantissa always sits just above guard/round in the widened magnitude.
  always_comb begin
    lead = 0;
    for (int i = 0; i < in_width; i++) begin
      if (s1_mag_q[i]) lead = i;
    end
    e_int     = lead - frac_bits + bias;
    normal    = !s1_zero_q && (e_int >= 1);
    sh        = normal ? (lead - man_width) : sub_sh;
    ext       = {s1_mag_q, {(man_width + 2){1'b0}}};
    lost_mask = (sh_one << (sh + man_width)) - sh_one;
  end

  always_comb begin
    inc     = s2_g_q && (s2_r_q || s2_s_q || s2_man_q[0]);
    man_sum = {1'b0, s2_man_q} + (man_width + 1)'(inc);
    // A mantissa carry leaves man_sum's low bits at zero; a subnormal carry lands on exp 1.
    exp_r   = s2_exp_q + ef_w'(man_sum[man_width]);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_mag_d   = s1_mag_q;
    s2_valid_d = s2_valid_q;
    s2_sign_d  = s2_sign_q;
    s2_exp_d   = s2_exp_q;
    s2_man_d   = s2_man_q;
    s2_g_d     = s2_g_q;
    s2_r_d     = s2_r_q;
    s2_s_d     = s2_s_q;
    o_valid_d  = o_valid_q;
    o_fp_d     = o_fp_q;
    if (en) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_sign_d = i_data[in_width-1];
        s1_mag_d  = i_data[in_width-1] ? (~i_data + in_width'(1)) : i_data;
        s1_zero_d = (i_data == '0);
      end

      s2_valid_d = s1_valid_q;
      s2_sign_d  = s1_sign_q;
      s2_exp_d   = normal ? ef_w'(e_int) : '0;
      s2_man_d   = ext[sh + man_width + 2 +: man_width];
      s2_g_d     = ext[sh + man_width + 1];
      s2_r_d     = ext[sh + man_width];
      s2_s_d     = |(ext & lost_mask);

      o_valid_d = s2_valid_q;
      if (exp_r > ef_w'(exp_max)) begin
        o_fp_d = {s2_sign_q, exp_width'(exp_max), {man_width{1'b1}}};
      end else begin
        o_fp_d = {s2_sign_q, exp_r[exp_width-1:0], man_sum[man_width-1:0]};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_mag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_man_q   <= '0;
      s2_g_q     <= 1'b0;
      s2_r_q     <= 1'b0;
      s2_s_q     <= 1'b0;
      o_valid_q  <= 1'b0;
      o_fp_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_mag_q   <= s1_mag_d;
      s2_valid_q <= s2_valid_d;
      s2_sign_q  <= s2_sign_d;
      s2_exp_q   <= s2_exp_d;
      s2_man_q   <= s2_man_d;
      s2_g_q     <= s2_g_d;
      s2_r_q     <= s2_r_d;
      s2_s_q     <= s2_s_d;
      o_valid_q  <= o_valid_d;
      o_fp_q     <= o_fp_d;
    end
  end

endmodule

// File: tb/tb_fxp_to_fp_enc.sv
// Directed bench for fxp_to_fp_enc (E5M2, 32 fraction bits): latency, rounding,
// subnormals, saturation, backpressure and asynchronous reset.
module tb_fxp_to_fp_enc;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [72:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_fp;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] got[$];

  logic [72:0] b_in[14];
  logic [7:0]  b_exp[14];
  logic [72:0] bp_in[6];
  logic [7:0]  bp_exp[6];

  fxp_to_fp_enc dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_fp   (o_fp)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) got.push_back(o_fp);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [72:0] neg(input logic [72:0] x);
    return ~x + 73'd1;
  endfunction

  task automatic lat_test(input string tag, input logic [72:0] d, input logic [7:0] want);
    int n;
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    i_data  = d;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    n = 1;
    @(negedge i_clk);
    while (!o_valid && n < 10) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_val"}, o_fp, want);
    repeat (3) @(posedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int idx;
    int cnt;
    logic [7:0] held;

    b_in[0]  = 73'd9 << 29;                    b_exp[0]  = 8'h3C;
    b_in[1]  = 73'd11 << 29;                   b_exp[1]  = 8'h3E;
    b_in[2]  = (73'd5 << 30) + (73'd1 << 12);  b_exp[2]  = 8'h3D;
    b_in[3]  = 73'd1 << 16;                    b_exp[3]  = 8'h01;
    b_in[4]  = 73'd1 << 15;                    b_exp[4]  = 8'h00;
    b_in[5]  = 73'd3 << 15;                    b_exp[5]  = 8'h02;
    b_in[6]  = neg(73'd1 << 15);               b_exp[6]  = 8'h80;
    b_in[7]  = 73'd0;                          b_exp[7]  = 8'h00;
    b_in[8]  = 73'd57344 << 32;                b_exp[8]  = 8'h7B;
    b_in[9]  = 73'd61440 << 32;                b_exp[9]  = 8'h7B;
    b_in[10] = 73'd1 << 72;                    b_exp[10] = 8'hFB;
    b_in[11] = 73'd15 << 29;                   b_exp[11] = 8'h40;
    b_in[12] = neg(73'd1);                     b_exp[12] = 8'h80;
    b_in[13] = (73'd1 << 72) - 73'd1;          b_exp[13] = 8'h7B;

    bp_in[0] = 73'd1 << 32;         bp_exp[0] = 8'h3C;
    bp_in[1] = neg(73'd3 << 31);    bp_exp[1] = 8'hBE;
    bp_in[2] = 73'd1 << 16;         bp_exp[2] = 8'h01;
    bp_in[3] = 73'd15 << 29;        bp_exp[3] = 8'h40;
    bp_in[4] = 73'd0;               bp_exp[4] = 8'h00;
    bp_in[5] = 73'd57344 << 32;     bp_exp[5] = 8'h7B;

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_fp", o_fp, 0);
    chk("rst_ready", o_ready, 1);
    @(posedge i_clk); #3;
    i_rst = 1'b0;

    lat_test("one", 73'd1 << 32, 8'h3C);
    lat_test("m1p5", neg(73'd3 << 31), 8'hBE);

    // back-to-back stream of rounding / subnormal / saturation vectors
    got.delete();
    for (int i = 0; i < 14; i++) begin
      @(posedge i_clk); #1;
      i_valid = 1'b1;
      i_data  = b_in[i];
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (6) @(posedge i_clk);
    chk("bulk_count", got.size(), 14);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("bulk%0d", i), (i < got.size()) ? got[i] : 8'hxx, b_exp[i]);
    end

    // backpressure: downstream stalls in cycles 4..7
    got.delete();
    idx  = 0;
    held = '0;
    for (int k = 0; k < 16; k++) begin
      @(posedge i_clk); #1;
      i_ready = !(k >= 4 && k <= 7);
      i_valid = (idx < 6);
      i_data  = (idx < 6) ? bp_in[idx] : 73'd0;
      @(negedge i_clk);
      if (i_valid && o_ready) idx++;
      if (k >= 4 && k <= 7) begin
        chk($sformatf("bp_ready%0d", k), o_ready, 0);
        chk($sformatf("bp_valid%0d", k), o_valid, 1);
        if (k == 4) held = o_fp;
        else chk($sformatf("bp_hold%0d", k), o_fp, held);
      end
      if (k >= 8 && k <= 12) chk($sformatf("bp_rate%0d", k), o_valid, 1);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("bp_held_val", held, 8'hBE);
    chk("bp_count", got.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp%0d", i), (i < got.size()) ? got[i] : 8'hxx, bp_exp[i]);
    end
    repeat (4) @(posedge i_clk);

    // asynchronous reset with two words in flight
    @(posedge i_clk); #1;
    i_valid = 1'b1;
    i_data  = 73'd1 << 32;
    @(posedge i_clk); #1;
    i_data  = neg(73'd3 << 31);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #2;
    chk("pre_rst_valid", o_valid, 1);
    i_rst = 1'b1;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_fp", o_fp, 0);
    chk("arst_ready", o_ready, 1);
    repeat (2) @(posedge i_clk);
    #3;
    i_rst = 1'b0;
    got.delete();
    cnt = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (o_valid) cnt++;
    end
    chk("rst_stale", cnt, 0);
    chk("rst_queue", got.size(), 0);
    lat_test("post_rst", 73'd11 << 29, 8'h3E);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fxp_to_fp_enc.md
Name: fxp_to_fp_enc

Overview:
- Pipelined encoder converting a signed fixed-point accumulator value (the integer sum produced by the FP dot-product datapath) back to a packed minifloat (sign | exponent | mantissa) with round-to-nearest-even and saturation.
- Sits after the dot-product adder tree so results can be stored and re-fed in the same element format.
- Valid/ready streaming interface with full-pipeline stall on backpressure.

Parameters:
- exp_width, 5, output exponent field width; bias = 2^(exp_width-1)-1.
- man_width, 2, output mantissa field width.
- in_width, 73, input fixed-point width (two's complement).
- frac_bits, 32, input LSB weight is 2^-frac_bits; default = 2*(bias-1+man_width).
- bit_width, 1+exp_width+man_width, output word width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_valid  in  1  input word valid.
- o_ready  out  1  encoder accepts input this cycle.
- i_data  in  in_width  signed fixed-point value = i_data * 2^-frac_bits.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts output.
- o_fp  out  bit_width  packed minifloat {sign, exp, man}.

Behaviour:
- Clocking/reset: one clock. Reset is asynchronous and active-high. While i_rst is high, all stage valid bits clear, o_valid=0, o_fp=0. o_ready is combinational and equals 1 whenever the pipeline is empty.
- Stall: en = !(o_valid && !i_ready); o_ready = en. All three stages advance together when en=1. Bubbles are not collapsed. Input transfers when i_valid && o_ready.
- Latency: exactly 3 cycles from accepted input to o_valid with no stall. Throughput is 1 word/cycle.
- o_fp and o_valid hold stable while o_valid && !i_ready.
- S1 (sign/magnitude):
  - sign = i_data MSB.
  - mag = |i_data| as in_width-bit unsigned. -2^(in_width-1) is handled without overflow.
  - zero flag = (mag==0).
- S2 (normalise):
  - p = index of leading one of mag.
  - E = p - frac_bits.
  - If E+bias >= 1: normal. exp_f = E+bias; keep man_width bits below the leading one.
  - Else: subnormal. exp_f = 0; mantissa = mag aligned so its LSB weight is 2^(1-bias-man_width).
  - Discarded bits are reduced to guard, round and sticky.
- S3 (round/pack):
  - RNE: increment when guard && (round || sticky || man_lsb).
  - Mantissa carry increments exp_f; a subnormal carry becomes exp_f=1.
  - If exp_f > 2^exp_width-2 after rounding: saturate to exp = 2^exp_width-2, man = all ones, sign kept. No inf/NaN is ever produced.
- Zero: input 0 gives o_fp=0. A nonzero value that rounds to zero gives a signed zero (sign kept, e.g. 0x80 for negative).
- Width rule: all internal shifts use in_width+man_width+2 bits; no truncation before sticky reduction.
- Reset mid-operation: in-flight words are discarded and not emitted after reset release.
- i_data is sampled only on a transfer. Behaviour with i_valid=0 is a don't-care input.

Test Plan (defaults, E5M2, frac_bits=32):
- i_data=2^32 (1.0) -> 0x3C. i_data=-(3*2^31) (-1.5) -> 0xBE. Each appears with o_valid exactly 3 cycles after acceptance.
- RNE ties:
  - 1.125 (9*2^29) -> 0x3C (round down to even).
  - 1.375 (11*2^29) -> 0x3E (round up to even).
  - 1.25+2^-20 -> 0x3D.
- Subnormals/zero:
  - 2^16 (2^-16) -> 0x01.
  - 2^15 (tie) -> 0x00.
  - 3*2^15 -> 0x02.
  - -2^15 -> 0x80.
  - 0 -> 0x00.
- Saturation/carry:
  - 57344*2^32 -> 0x7B.
  - 61440*2^32 -> 0x7B (rounding carry saturates).
  - -2^72 -> 0xFB.
  - 1.875*2^32 -> 0x40 (carry into exponent).
- Backpressure: stream 6 values with i_valid=1 and i_ready=0 for cycles 4-7. Required:
  - o_ready=0 during the stall.
  - o_fp held stable.
  - All 6 outputs appear in order with no loss or duplication.
  - Sustained 1/cycle once i_ready=1.
- Reset: assert i_rst asynchronously (mid-clock) with 2 words in flight. Required:
  - o_valid=0 and o_fp=0 immediately.
  - No stale output after release.
  - First post-reset input appears 3 cycles after acceptance.
